// File: rtl/piso_pkg.sv
// Shared types and constants for the serial transmit controller and its shift register.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  localparam logic SEL_LOAD  = 1'b0;
  localparam logic SEL_SHIFT = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Generic load/shift register; stage 0 drives sq and zeros fill in from the far end.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] pdata,
  output logic             sq
);

  logic [WIDTH-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else if (sel == SEL_LOAD) begin
      r_stage <= pdata;
    end else begin
      r_stage <= {1'b0, r_stage[WIDTH-1:1]};
    end
  end

  assign sq = r_stage[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serial transmit controller: valid/ready word intake, bit sequencing and frame markers
// around a load/shift register.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int unsigned     CntW    = cnt_w(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  tx_state_t       r_state;
  tx_state_t       w_state_nxt;
  logic [CntW-1:0] r_bit_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            w_sel;
  logic            w_last;
  logic            w_accept;
  logic            w_sq;
  logic [WIDTH-1:0] w_pdata;

  // Stage 0 is the output end, so the first bit to send must land there.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_map
    assign w_pdata[gi] = (LSB_FIRST != 0) ? in_data[gi] : in_data[WIDTH-1-gi];
  end

  assign w_last   = (r_state == SHIFT) && (r_bit_cnt == LastIdx);
  assign in_ready = !rst && ((r_state == IDLE) || w_last);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_sel       = SEL_SHIFT;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = '0;
      w_sel       = SEL_LOAD;
    end else if (r_state == SHIFT) begin
      if (r_bit_cnt == LastIdx) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_bit_cnt + CntW'(1);
      end
    end
  end

  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .sel  (w_sel),
    .pdata(w_pdata),
    .sq   (w_sq)
  );

  assign sout_valid  = (r_state == SHIFT);
  assign busy        = (r_state == SHIFT);
  assign sout        = w_sq & sout_valid;
  assign frame_start = (r_state == SHIFT) && (r_bit_cnt == '0);
  assign frame_end   = w_last;

endmodule
